// File: rtl/rgb_to_yuv_encoder_pkg.sv
// Shared constants for the colour-convert paths: plane bases, image size, YUV coefficients,
// plus the encoder FSM state type and small arithmetic helpers.
package rgb_to_yuv_encoder_pkg;

   localparam int unsigned DEF_IMG_WIDTH  = 320;
   localparam int unsigned DEF_IMG_HEIGHT = 240;

   localparam logic [17:0] DEF_Y_BASE   = 18'd0;
   localparam logic [17:0] DEF_U_BASE   = 18'd38400;
   localparam logic [17:0] DEF_V_BASE   = 18'd57600;
   localparam logic [17:0] DEF_RGB_BASE = 18'd146944;

   typedef enum logic [1:0] {S_ENC_IDLE, S_ENC_GRP, S_ENC_DONE} enc_state_type;

   localparam logic signed [17:0] C_YR =  18'sd66;
   localparam logic signed [17:0] C_YG =  18'sd129;
   localparam logic signed [17:0] C_YB =  18'sd25;
   localparam logic signed [17:0] C_UR = -18'sd38;
   localparam logic signed [17:0] C_UG = -18'sd74;
   localparam logic signed [17:0] C_UB =  18'sd112;
   localparam logic signed [17:0] C_VR =  18'sd112;
   localparam logic signed [17:0] C_VG = -18'sd94;
   localparam logic signed [17:0] C_VB = -18'sd18;
   localparam logic signed [17:0] C_RND    = 18'sd128;
   localparam logic signed [17:0] C_Y_OFS  = 18'sd16;
   localparam logic signed [17:0] C_UV_OFS = 18'sd128;

   function automatic logic [7:0] clip8(input logic signed [17:0] x);
      if (x < 18'sd0)        return 8'd0;
      else if (x > 18'sd255) return 8'd255;
      else                   return x[7:0];
   endfunction

   // Rounded pair average; the 9-bit sum cannot overflow.
   function automatic logic [7:0] avg2(input logic [7:0] a, input logic [7:0] b);
      return 8'(({1'b0, a} + {1'b0, b} + 9'd1) >> 1);
   endfunction

endpackage

// File: rtl/rgb2yuv_pixel.sv
// Single-pixel RGB -> YUV converter: multiply, round, offset and clip, with a registered output
// one cycle after the inputs are presented.
module rgb2yuv_pixel
   import rgb_to_yuv_encoder_pkg::*;
(
   input  logic       CLOCK_50_I,
   input  logic       resetn,
   input  logic [7:0] r,
   input  logic [7:0] g,
   input  logic [7:0] b,
   output logic [7:0] y,
   output logic [7:0] u,
   output logic [7:0] v
);

   logic signed [17:0] r_s, g_s, b_s;
   logic signed [17:0] y_acc, u_acc, v_acc;

   always_comb begin
      r_s   = $signed({10'd0, r});
      g_s   = $signed({10'd0, g});
      b_s   = $signed({10'd0, b});
      y_acc = ((C_YR * r_s + C_YG * g_s + C_YB * b_s + C_RND) >>> 8) + C_Y_OFS;
      u_acc = ((C_UR * r_s + C_UG * g_s + C_UB * b_s + C_RND) >>> 8) + C_UV_OFS;
      v_acc = ((C_VR * r_s + C_VG * g_s + C_VB * b_s + C_RND) >>> 8) + C_UV_OFS;
   end

   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) begin
         y <= 8'd0;
         u <= 8'd0;
         v <= 8'd0;
      end else begin
         y <= clip8(y_acc);
         u <= clip8(u_acc);
         v <= clip8(v_acc);
      end
   end

endmodule

// File: rtl/rgb_to_yuv_encoder.sv
// Frame encoder: streams interleaved RGB from SRAM, converts to YUV and writes Y plus 2:1
// horizontally decimated U/V planes back, one 4-pixel group every 12 cycles.
module rgb_to_yuv_encoder
   import rgb_to_yuv_encoder_pkg::*;
#(
   parameter int unsigned IMG_WIDTH  = DEF_IMG_WIDTH,
   parameter int unsigned IMG_HEIGHT = DEF_IMG_HEIGHT,
   parameter logic [17:0] Y_BASE     = DEF_Y_BASE,
   parameter logic [17:0] U_BASE     = DEF_U_BASE,
   parameter logic [17:0] V_BASE     = DEF_V_BASE,
   parameter logic [17:0] RGB_BASE   = DEF_RGB_BASE
) (
   input  logic        CLOCK_50_I,
   input  logic        resetn,
   input  logic        enc_start,
   output logic        enc_done,
   output logic [17:0] SRAM_address,
   output logic [15:0] SRAM_write_data,
   output logic        SRAM_we_n,
   input  logic [15:0] SRAM_read_data
);

   localparam int unsigned NUM_GRP  = IMG_WIDTH * IMG_HEIGHT / 4;
   localparam logic [14:0] LAST_GRP = 15'(NUM_GRP - 1);

   enc_state_type state;
   logic [3:0]    phase;
   logic [14:0]   grp;
   logic [17:0]   rgb_ptr, y_ptr, u_ptr, v_ptr;
   logic [15:0]   word0, word3;
   logic [7:0]    red1, red3;
   logic [7:0]    y_pix [4];
   logic [7:0]    u_pix [4];
   logic [7:0]    v_pix [4];
   logic [7:0]    r_in, g_in, b_in;
   logic [7:0]    y_out, u_out, v_out;

   // Assemble each pixel in the cycle its last byte arrives on the read bus.
   always_comb begin
      r_in = word0[15:8];
      g_in = word0[7:0];
      b_in = SRAM_read_data[15:8];
      case (phase)
         4'd4: begin
            r_in = red1;
            g_in = SRAM_read_data[15:8];
            b_in = SRAM_read_data[7:0];
         end
         4'd6: begin
            r_in = word3[15:8];
            g_in = word3[7:0];
            b_in = SRAM_read_data[15:8];
         end
         4'd7: begin
            r_in = red3;
            g_in = SRAM_read_data[15:8];
            b_in = SRAM_read_data[7:0];
         end
         default: ;
      endcase
   end

   rgb2yuv_pixel u_pixel (
      .CLOCK_50_I (CLOCK_50_I),
      .resetn     (resetn),
      .r          (r_in),
      .g          (g_in),
      .b          (b_in),
      .y          (y_out),
      .u          (u_out),
      .v          (v_out)
   );

   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) begin
         state           <= S_ENC_IDLE;
         phase           <= 4'd0;
         grp             <= 15'd0;
         rgb_ptr         <= RGB_BASE;
         y_ptr           <= Y_BASE;
         u_ptr           <= U_BASE;
         v_ptr           <= V_BASE;
         word0           <= 16'd0;
         word3           <= 16'd0;
         red1            <= 8'd0;
         red3            <= 8'd0;
         for (int i = 0; i < 4; i++) begin
            y_pix[i] <= 8'd0;
            u_pix[i] <= 8'd0;
            v_pix[i] <= 8'd0;
         end
         enc_done        <= 1'b0;
         SRAM_address    <= RGB_BASE;
         SRAM_write_data <= 16'd0;
         SRAM_we_n       <= 1'b1;
      end else begin
         enc_done <= 1'b0;
         case (state)
            S_ENC_IDLE: begin
               SRAM_we_n <= 1'b1;
               if (enc_start) begin
                  rgb_ptr      <= RGB_BASE;
                  y_ptr        <= Y_BASE;
                  u_ptr        <= U_BASE;
                  v_ptr        <= V_BASE;
                  grp          <= 15'd0;
                  phase        <= 4'd0;
                  SRAM_address <= RGB_BASE;
                  state        <= S_ENC_GRP;
               end
            end
            S_ENC_GRP: begin
               phase <= phase + 4'd1;
               if (phase <= 4'd4) SRAM_address <= rgb_ptr + 18'(phase) + 18'd1;
               case (phase)
                  4'd2: word0 <= SRAM_read_data;
                  4'd3: red1  <= SRAM_read_data[7:0];
                  4'd5: word3 <= SRAM_read_data;
                  4'd6: red3  <= SRAM_read_data[7:0];
                  default: ;
               endcase
               // Converter output for p0..p3 is valid at phases 4, 5, 7 and 8.
               case (phase)
                  4'd4: begin y_pix[0] <= y_out; u_pix[0] <= u_out; v_pix[0] <= v_out; end
                  4'd5: begin y_pix[1] <= y_out; u_pix[1] <= u_out; v_pix[1] <= v_out; end
                  4'd7: begin y_pix[2] <= y_out; u_pix[2] <= u_out; v_pix[2] <= v_out; end
                  4'd8: begin y_pix[3] <= y_out; u_pix[3] <= u_out; v_pix[3] <= v_out; end
                  default: ;
               endcase
               case (phase)
                  4'd7: begin
                     SRAM_address    <= y_ptr;
                     SRAM_write_data <= {y_pix[0], y_pix[1]};
                     SRAM_we_n       <= 1'b0;
                  end
                  4'd8: begin
                     SRAM_address    <= y_ptr + 18'd1;
                     SRAM_write_data <= {y_pix[2], y_out};
                     y_ptr           <= y_ptr + 18'd2;
                  end
                  4'd9: begin
                     SRAM_address    <= u_ptr;
                     SRAM_write_data <= {avg2(u_pix[0], u_pix[1]), avg2(u_pix[2], u_pix[3])};
                     u_ptr           <= u_ptr + 18'd1;
                  end
                  4'd10: begin
                     SRAM_address    <= v_ptr;
                     SRAM_write_data <= {avg2(v_pix[0], v_pix[1]), avg2(v_pix[2], v_pix[3])};
                     v_ptr           <= v_ptr + 18'd1;
                  end
                  4'd11: begin
                     SRAM_we_n <= 1'b1;
                     if (grp == LAST_GRP) begin
                        state    <= S_ENC_DONE;
                        enc_done <= 1'b1;
                     end else begin
                        grp          <= grp + 15'd1;
                        phase        <= 4'd0;
                        rgb_ptr      <= rgb_ptr + 18'd6;
                        SRAM_address <= rgb_ptr + 18'd6;
                     end
                  end
                  default: ;
               endcase
            end
            S_ENC_DONE: begin
               SRAM_we_n <= 1'b1;
               state     <= S_ENC_IDLE;
            end
            default: state <= S_ENC_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rgb_to_yuv_encoder.sv
// Directed bench for rgb_to_yuv_encoder on a reduced 16x8 frame with a behavioural SRAM.
module tb_rgb_to_yuv_encoder;

   localparam int unsigned W = 16;
   localparam int unsigned H = 8;
   localparam int unsigned G = W * H / 4;
   localparam int unsigned YB = 0;
   localparam int unsigned UB = 38400;
   localparam int unsigned VB = 57600;
   localparam int unsigned RB = 146944;

   logic        CLOCK_50_I = 1'b0;
   logic        resetn     = 1'b0;
   logic        enc_start  = 1'b0;
   logic        enc_done;
   logic [17:0] SRAM_address;
   logic [15:0] SRAM_write_data;
   logic        SRAM_we_n;
   logic [15:0] SRAM_read_data = 16'd0;
   logic [17:0] addr_d1 = 18'd0;

   logic [15:0] mem [int unsigned];

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [3:0][23:0] rgb;   // {p3, p2, p1, p0}, each {R, G, B}
      logic [15:0]      y0;
      logic [15:0]      y1;
      logic [15:0]      u;
      logic [15:0]      v;
   } vec_t;

   vec_t vecs [5];

   rgb_to_yuv_encoder #(
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H)
   ) dut (
      .CLOCK_50_I      (CLOCK_50_I),
      .resetn          (resetn),
      .enc_start       (enc_start),
      .enc_done        (enc_done),
      .SRAM_address    (SRAM_address),
      .SRAM_write_data (SRAM_write_data),
      .SRAM_we_n       (SRAM_we_n),
      .SRAM_read_data  (SRAM_read_data)
   );

   always #10 CLOCK_50_I = ~CLOCK_50_I;

   // Read data appears two cycles after the address is presented.
   always @(posedge CLOCK_50_I) begin
      addr_d1        <= SRAM_address;
      SRAM_read_data <= mem.exists(32'(addr_d1)) ? mem[32'(addr_d1)] : 16'h0000;
   end

   function automatic logic [15:0] mem_get(input int unsigned a);
      return mem.exists(a) ? mem[a] : 16'hBEEF;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic load(input vec_t v);
      logic [23:0] p [4];
      for (int i = 0; i < 4; i++) p[i] = v.rgb[i];
      mem.delete();
      for (int unsigned g = 0; g < G; g++) begin
         mem[RB + 6*g + 0] = {p[0][23:16], p[0][15:8]};
         mem[RB + 6*g + 1] = {p[0][7:0],   p[1][23:16]};
         mem[RB + 6*g + 2] = {p[1][15:8],  p[1][7:0]};
         mem[RB + 6*g + 3] = {p[2][23:16], p[2][15:8]};
         mem[RB + 6*g + 4] = {p[2][7:0],   p[3][23:16]};
         mem[RB + 6*g + 5] = {p[3][15:8],  p[3][7:0]};
         mem[YB + 2*g]     = 16'hDEAD;
         mem[YB + 2*g + 1] = 16'hDEAD;
         mem[UB + g]       = 16'hDEAD;
         mem[VB + g]       = 16'hDEAD;
      end
   endtask

   // Starts a frame and observes it mid-cycle; cycle j=0 is c0 of group 0.
   task automatic run_frame(input int repulse_grp);
      int          first_wr = -1, last_wr = -1, done_at = -1, n_wr = 0, n_done = 0;
      logic [17:0] first_addr = '0, last_addr = '0;
      @(negedge CLOCK_50_I);
      enc_start = 1'b1;
      @(negedge CLOCK_50_I);
      enc_start = 1'b0;
      chk("start_addr", 32'(SRAM_address), RB);
      chk("start_we_n", 32'(SRAM_we_n), 1);
      for (int j = 0; j < int'(12*G) + 8; j++) begin
         if (!SRAM_we_n) begin
            mem[32'(SRAM_address)] = SRAM_write_data;
            n_wr++;
            if (first_wr < 0) begin
               first_wr   = j;
               first_addr = SRAM_address;
            end
            last_wr   = j;
            last_addr = SRAM_address;
         end
         if (enc_done) begin
            n_done++;
            if (done_at < 0) done_at = j;
         end
         enc_start = (repulse_grp >= 0 && j == repulse_grp * 12);
         @(negedge CLOCK_50_I);
      end
      enc_start = 1'b0;
      chk("first_write_cycle", first_wr, 8);
      chk("first_write_addr", 32'(first_addr), YB);
      chk("last_write_cycle", last_wr, 12*G - 1);
      chk("last_write_addr", 32'(last_addr), VB + G - 1);
      chk("done_cycle", done_at, 12*G);
      chk("done_count", n_done, 1);
      chk("write_count", n_wr, 4*G);
   endtask

   task automatic check_data(input int idx, input vec_t v);
      for (int unsigned g = 0; g < G; g++) begin
         chk($sformatf("y0 v%0d g%0d", idx, g), 32'(mem_get(YB + 2*g)), 32'(v.y0));
         chk($sformatf("y1 v%0d g%0d", idx, g), 32'(mem_get(YB + 2*g + 1)), 32'(v.y1));
         chk($sformatf("u v%0d g%0d", idx, g), 32'(mem_get(UB + g)), 32'(v.u));
         chk($sformatf("v v%0d g%0d", idx, g), 32'(mem_get(VB + g)), 32'(v.v));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_addr"}, 32'(SRAM_address), RB);
      chk({tag, "_we_n"}, 32'(SRAM_we_n), 1);
      chk({tag, "_wdata"}, 32'(SRAM_write_data), 0);
      chk({tag, "_done"}, 32'(enc_done), 0);
   endtask

   initial begin
      // black, white, red, red/black, mixed {black, white, red, blue}
      vecs[0] = '{rgb: {24'h000000, 24'h000000, 24'h000000, 24'h000000},
                  y0: 16'h1010, y1: 16'h1010, u: 16'h8080, v: 16'h8080};
      vecs[1] = '{rgb: {24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF},
                  y0: 16'hEBEB, y1: 16'hEBEB, u: 16'h8080, v: 16'h8080};
      vecs[2] = '{rgb: {24'hFF0000, 24'hFF0000, 24'hFF0000, 24'hFF0000},
                  y0: 16'h5252, y1: 16'h5252, u: 16'h5A5A, v: 16'hF0F0};
      vecs[3] = '{rgb: {24'h000000, 24'hFF0000, 24'h000000, 24'hFF0000},
                  y0: 16'h5210, y1: 16'h5210, u: 16'h6D6D, v: 16'hB8B8};
      vecs[4] = '{rgb: {24'h0000FF, 24'hFF0000, 24'hFFFFFF, 24'h000000},
                  y0: 16'h10EB, y1: 16'h5229, u: 16'h80A5, v: 16'h80AF};

      repeat (2) @(negedge CLOCK_50_I);
      check_reset_outputs("in_reset");
      resetn = 1'b1;
      repeat (3) @(negedge CLOCK_50_I);
      check_reset_outputs("idle");

      for (int i = 0; i < 5; i++) begin
         load(vecs[i]);
         run_frame(i == 2 ? 2 : -1);
         check_data(i, vecs[i]);
      end

      // Abort mid-frame, then a fresh start must begin again from pixel 0.
      load(vecs[2]);
      @(negedge CLOCK_50_I);
      enc_start = 1'b1;
      @(negedge CLOCK_50_I);
      enc_start = 1'b0;
      repeat (5*12 + 3) @(negedge CLOCK_50_I);
      resetn = 1'b0;
      #1;
      check_reset_outputs("abort");
      @(negedge CLOCK_50_I);
      resetn = 1'b1;
      repeat (3) @(negedge CLOCK_50_I);
      check_reset_outputs("post_abort");
      load(vecs[1]);
      run_frame(-1);
      check_data(5, vecs[1]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
